reg_writeback: RTL and testbench

Writeback unit that drives the write port of the 16x32 register file. Merges results from the ALU and the load unit into a single registered write per cycle, buffers contending results in an in-order queue, and keeps a per-register busy scoreboard for the issue stage. Sits between the execute/memory stages and the register file.

---
 rtl/reg_writeback_pkg.sv | 13 +
 rtl/reg_writeback_if.sv | 41 ++++
 rtl/reg_writeback_wb_fifo.sv | 53 +++++
 rtl/reg_writeback.sv | 122 ++++++++++++
 tb/tb_reg_writeback.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/reg_writeback_pkg.sv
// Shared types and sizes for the writeback unit and its result queue.
package reg_writeback_pkg;

  localparam int REG_AW   = 4;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 16;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/reg_writeback_if.sv
// Result sources, issue-stage scoreboard port and register-file write port.
interface reg_writeback_if
  import reg_writeback_pkg::*;
#(
  parameter int DEPTH = 4
) ();

  localparam int CW = $clog2(DEPTH) + 1;

  logic              alu_valid;
  logic [REG_AW-1:0] alu_rd;
  logic [DATA_W-1:0] alu_data;
  logic              alu_ready;

  logic              ld_valid;
  logic [REG_AW-1:0] ld_rd;
  logic [DATA_W-1:0] ld_data;
  logic              ld_ready;

  logic              iss_valid;
  logic [REG_AW-1:0] iss_rd;
  logic [NUM_REGS-1:0] busy;

  logic              write;
  logic [REG_AW-1:0] addrw;
  logic [DATA_W-1:0] datain;
  logic [CW-1:0]     wb_count;

  // Upstream stages and the register file.
  modport master (
    output alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data, iss_valid, iss_rd,
    input  alu_ready, ld_ready, busy, write, addrw, datain, wb_count
  );

  // The writeback unit.
  modport slave (
    input  alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data, iss_valid, iss_rd,
    output alu_ready, ld_ready, busy, write, addrw, datain, wb_count
  );

endinterface

// File: rtl/reg_writeback_wb_fifo.sv
// In-order result queue: two write ports (port 0 older than port 1), one read port.
module wb_fifo
  import reg_writeback_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push0,
  input  wb_entry_t                  push0_data,
  input  logic                       push1,
  input  wb_entry_t                  push1_data,
  input  logic                       pop,
  output wb_entry_t                  head,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  wb_entry_t     mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr_b;
  logic [AW:0]   cnt;

  // Second write lands behind the first when both ports fire.
  assign wr_ptr_b = push0 ? wr_ptr + AW'(1) : wr_ptr;

  // NOTE: storage has no reset; entries are only read once the pointers say they are valid.
  always_ff @(posedge clk) begin
    if (push0) mem[wr_ptr]   <= push0_data;
    if (push1) mem[wr_ptr_b] <= push1_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push0) + AW'(push1);
      rd_ptr <= rd_ptr + AW'(pop);
      cnt    <= cnt + (AW+1)'(push0) + (AW+1)'(push1) - (AW+1)'(pop);
    end
  end

  assign head  = mem[rd_ptr];
  assign empty = (cnt == '0);
  assign count = cnt;

endmodule

// File: rtl/reg_writeback.sv
// Writeback unit: merges ALU and load results into one registered register-file
// write per cycle, queues contending results in order, and tracks busy registers.
module reg_writeback
  import reg_writeback_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  reg_writeback_if.slave bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [CW-1:0]       count;
  logic                fifo_empty;
  wb_entry_t           head;
  logic                ready;
  logic                alu_acc;
  logic                ld_acc;
  wb_entry_t           alu_e;
  wb_entry_t           ld_e;

  logic                cand_valid;
  wb_entry_t           cand;
  logic                pop;
  logic                push0;
  logic                push1;
  wb_entry_t           push0_data;
  wb_entry_t           push1_data;

  logic                write_q;
  logic [REG_AW-1:0]   addrw_q;
  logic [DATA_W-1:0]   datain_q;
  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_next;

  // Threshold leaves room for two enqueues, so the queue can never overflow.
  assign ready   = (count <= CW'(DEPTH - 2));
  assign alu_acc = bus.alu_valid & ready;
  assign ld_acc  = bus.ld_valid & ready;
  assign alu_e   = '{rd: bus.alu_rd, data: bus.alu_data};
  assign ld_e    = '{rd: bus.ld_rd,  data: bus.ld_data};

  // Oldest first: queue head, then this cycle's ALU result, then its load result.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    cand_valid = 1'b0;
    cand       = '0;
    pop        = 1'b0;
    push0      = 1'b0;
    push0_data = '0;
    push1      = 1'b0;
    push1_data = '0;
    if (!fifo_empty) begin
      cand_valid = 1'b1;
      cand       = head;
      pop        = 1'b1;
      push0      = alu_acc | ld_acc;
      push0_data = alu_acc ? alu_e : ld_e;
      push1      = alu_acc & ld_acc;
      push1_data = ld_e;
    end else if (alu_acc) begin
      cand_valid = 1'b1;
      cand       = alu_e;
      push0      = ld_acc;
      push0_data = ld_e;
    end else if (ld_acc) begin
      cand_valid = 1'b1;
      cand       = ld_e;
    end
  end

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push0      (push0),
    .push0_data (push0_data),
    .push1      (push1),
    .push1_data (push1_data),
    .pop        (pop),
    .head       (head),
    .empty      (fifo_empty),
    .count      (count)
  );

  // Address and data hold their last written value while idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      write_q  <= 1'b0;
      addrw_q  <= '0;
      datain_q <= '0;
    end else begin
      write_q <= cand_valid;
      if (cand_valid) begin
        addrw_q  <= cand.rd;
        datain_q <= cand.data;
      end
    end
  end

  // Commit clears first, issue sets after, so a same-edge collision leaves the bit set.
  always_comb begin
    busy_next = busy_q;
    if (write_q)       busy_next[addrw_q]    = 1'b0;
    if (bus.iss_valid) busy_next[bus.iss_rd] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) busy_q <= '0;
    else      busy_q <= busy_next;
  end

  assign bus.alu_ready = ready;
  assign bus.ld_ready  = ready;
  assign bus.write     = write_q;
  assign bus.addrw     = addrw_q;
  assign bus.datain    = datain_q;
  assign bus.busy      = busy_q;
  assign bus.wb_count  = count;

endmodule

// File: tb/tb_reg_writeback.sv
// Self-checking bench for reg_writeback: in-order result-list model plus directed literal checks.
module tb_reg_writeback;

  localparam int DEPTH = 4;

  typedef struct {
    logic [3:0]  rd;
    logic [31:0] data;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  reg_writeback_if #(.DEPTH(DEPTH)) bus ();

  reg_writeback #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: results accepted but not yet written, oldest first; one leaves per edge.
  ent_t        mq[$];
  logic        m_write;
  logic [3:0]  m_addrw;
  logic [31:0] m_data;
  logic [15:0] m_busy;
  logic        m_rdy_last;

  always @(posedge clk or negedge rst) begin : model
    logic rdy;
    ent_t e;
    if (!rst) begin
      mq.delete();
      m_write    = 1'b0;
      m_addrw    = '0;
      m_data     = '0;
      m_busy     = '0;
      m_rdy_last = 1'b1;
    end else begin
      rdy = (mq.size() <= DEPTH - 2);
      if (m_write) m_busy[m_addrw] = 1'b0;
      if (bus.iss_valid) m_busy[bus.iss_rd] = 1'b1;
      if (bus.alu_valid && rdy) mq.push_back('{rd: bus.alu_rd, data: bus.alu_data});
      if (bus.ld_valid && rdy)  mq.push_back('{rd: bus.ld_rd,  data: bus.ld_data});
      if (mq.size() > 0) begin
        e       = mq.pop_front();
        m_write = 1'b1;
        m_addrw = e.rd;
        m_data  = e.data;
      end else begin
        m_write = 1'b0;
      end
      m_rdy_last = rdy;
    end
  end

  always @(negedge clk) begin
    if (rst && chk_en) begin
      check("alu_ready", 32'(bus.alu_ready), 32'(mq.size() <= DEPTH - 2));
      check("ld_ready",  32'(bus.ld_ready),  32'(mq.size() <= DEPTH - 2));
      check("write",     32'(bus.write),     32'(m_write));
      check("addrw",     32'(bus.addrw),     32'(m_addrw));
      check("datain",    bus.datain,         m_data);
      check("busy",      32'(bus.busy),      32'(m_busy));
      check("wb_count",  32'(bus.wb_count),  32'(mq.size()));
    end
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
    bus.ld_valid  = 1'b0; bus.ld_rd  = '0; bus.ld_data  = '0;
    bus.iss_valid = 1'b0; bus.iss_rd = '0;
  endtask

  task automatic drive_random();
    logic [3:0] r;
    if (!(bus.alu_valid && !m_rdy_last)) begin
      bus.alu_valid = ($urandom_range(0, 99) < 60);
      bus.alu_rd    = 4'($urandom);
      bus.alu_data  = $urandom;
    end
    if (!(bus.ld_valid && !m_rdy_last)) begin
      bus.ld_valid = ($urandom_range(0, 99) < 50);
      bus.ld_rd    = 4'($urandom);
      bus.ld_data  = $urandom;
    end
    r = 4'($urandom);
    bus.iss_rd    = r;
    bus.iss_valid = ($urandom_range(0, 3) == 0) && (!m_busy[r] || (m_write && m_addrw == r));
  endtask

  int exp_cnt [8] = '{1, 2, 3, 2, 3, 2, 3, 2};

  initial begin
    int k;
    clear_inputs();
    repeat (2) cyc();
    check("rst_write", 32'(bus.write), 32'd0);
    check("rst_busy",  32'(bus.busy), 32'd0);
    check("rst_count", 32'(bus.wb_count), 32'd0);
    rst = 1'b1;
    chk_en = 1'b1;
    cyc();
    check("rst_ready", 32'(bus.alu_ready), 32'd1);

    // Single ALU result to r5, after r5 has been marked busy by issue.
    bus.iss_valid = 1'b1; bus.iss_rd = 4'd5;
    cyc();
    bus.iss_valid = 1'b0;
    bus.alu_valid = 1'b1; bus.alu_rd = 4'd5; bus.alu_data = 32'hDEAD_BEEF;
    cyc();
    bus.alu_valid = 1'b0;
    check("single_write", 32'(bus.write), 32'd1);
    check("single_addr",  32'(bus.addrw), 32'd5);
    check("single_data",  bus.datain, 32'hDEAD_BEEF);
    check("single_busy5", 32'(bus.busy[5]), 32'd1);
    cyc();
    check("single_clr5",  32'(bus.busy[5]), 32'd0);
    check("single_idle",  32'(bus.write), 32'd0);

    // ALU and load together: ALU writes first, load follows from the queue.
    bus.alu_valid = 1'b1; bus.alu_rd = 4'd2; bus.alu_data = 32'h11;
    bus.ld_valid  = 1'b1; bus.ld_rd  = 4'd3; bus.ld_data  = 32'h22;
    cyc();
    clear_inputs();
    check("dual_addr0",  32'(bus.addrw), 32'd2);
    check("dual_data0",  bus.datain, 32'h11);
    check("dual_count0", 32'(bus.wb_count), 32'd1);
    cyc();
    check("dual_addr1",  32'(bus.addrw), 32'd3);
    check("dual_data1",  bus.datain, 32'h22);
    check("dual_count1", 32'(bus.wb_count), 32'd0);
    cyc();
    check("dual_idle",   32'(bus.write), 32'd0);

    // Issue to r7 on the very edge that commits r7: busy must stay set.
    bus.iss_valid = 1'b1; bus.iss_rd = 4'd7;
    cyc();
    bus.iss_valid = 1'b0;
    bus.alu_valid = 1'b1; bus.alu_rd = 4'd7; bus.alu_data = 32'h77;
    cyc();
    bus.alu_valid = 1'b0;
    check("coll_addr", 32'(bus.addrw), 32'd7);
    bus.iss_valid = 1'b1; bus.iss_rd = 4'd7;
    cyc();
    bus.iss_valid = 1'b0;
    check("coll_busy7", 32'(bus.busy[7]), 32'd1);

    // Both sources every cycle: occupancy climbs to 3, ready drops, held results go later.
    k = 0;
    bus.alu_valid = 1'b1; bus.alu_rd = 4'd8; bus.alu_data = 32'hA000_0000;
    bus.ld_valid  = 1'b1; bus.ld_rd  = 4'd9; bus.ld_data  = 32'hB000_0000;
    for (int i = 0; i < 8; i++) begin
      cyc();
      check("bp_count", 32'(bus.wb_count), 32'(exp_cnt[i]));
      check("bp_ready", 32'(bus.alu_ready), 32'(exp_cnt[i] <= DEPTH - 2));
      if (m_rdy_last) begin
        k++;
        bus.alu_rd = 4'(8 + k); bus.alu_data = 32'hA000_0000 + 32'(k);
        bus.ld_rd  = 4'(9 + k); bus.ld_data  = 32'hB000_0000 + 32'(k);
      end
    end
    clear_inputs();
    repeat (6) cyc();

    // Idle after a known last write: address and data hold.
    bus.alu_valid = 1'b1; bus.alu_rd = 4'd4; bus.alu_data = 32'hCAFE_F00D;
    cyc();
    bus.alu_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      check("idle_write", 32'(bus.write), 32'd0);
      check("idle_addr",  32'(bus.addrw), 32'd4);
      check("idle_data",  bus.datain, 32'hCAFE_F00D);
    end

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      drive_random();
      cyc();
    end
    clear_inputs();
    repeat (8) cyc();
    check("drain_count", 32'(bus.wb_count), 32'd0);

    // Reset with three results queued and a busy bit set.
    bus.alu_valid = 1'b1; bus.alu_rd = 4'd1; bus.alu_data = 32'h1;
    bus.ld_valid  = 1'b1; bus.ld_rd  = 4'd2; bus.ld_data  = 32'h2;
    bus.iss_valid = !m_busy[15] || (m_write && m_addrw == 4'd15); bus.iss_rd = 4'd15;
    for (int i = 0; i < 3; i++) begin
      cyc();
      bus.iss_valid = 1'b0;
      bus.alu_data = bus.alu_data + 32'd2;
      bus.ld_data  = bus.ld_data + 32'd2;
    end
    check("pre_rst_count", 32'(bus.wb_count), 32'd3);
    check("pre_rst_busy15", 32'(bus.busy[15]), 32'd1);
    #2 rst = 1'b0;
    #1;
    clear_inputs();
    check("mid_rst_write", 32'(bus.write), 32'd0);
    check("mid_rst_busy",  32'(bus.busy), 32'd0);
    check("mid_rst_count", 32'(bus.wb_count), 32'd0);
    cyc();
    rst = 1'b1;
    #1;
    check("post_rst_ready", 32'(bus.ld_ready), 32'd1);
    for (int i = 0; i < 200; i++) begin
      drive_random();
      cyc();
    end
    clear_inputs();
    repeat (4) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
